lvds_urng_clz: RTL and testbench

- Collects a serial entropy bit stream (LVDS comparator output) into an N-bit uniform random word.
- Carries a per-bit fill-valid vector alongside the word.
- A registered count-leading-zeros unit (sub-module) runs on a configurable field of the word.
- Sits in front of the uniform-to-float converter of the Gaussian RNG; the consumer reads the word once full, then pulses rst to request a fresh word.

---
 rtl/lvds_urng_clz_pkg.sv | 23 ++
 rtl/lvds_urng_clz_if.sv | 34 +++
 rtl/lvds_urng_clz_clz_reg.sv | 44 ++++
 rtl/lvds_urng_clz.sv | 94 +++++++++
 tb/tb_lvds_urng_clz.sv | 213 +++++++++++++++++++++
 5 files changed

// File: rtl/lvds_urng_clz_pkg.sv
// rtl/lvds_urng_clz_pkg.sv - shared defaults, pair-phase type and clog2 helper for the entropy collector
// Optional feature macro: URNG_VON_NEUMANN_EN (Von Neumann debiasing of the raw bit stream)
package lvds_urng_clz_pkg;

   localparam int DEF_N       = 32;
   localparam int DEF_CLZ_LSB = 16;
   localparam int DEF_CLZ_BW  = 14;

   // Which half of a debiasing pair the next sampled bit belongs to
   typedef enum logic {
      PH_FIRST  = 1'b0,
      PH_SECOND = 1'b1
   } vn_phase_e;

   // Ceiling log2, usable in constant expressions for port widths
   function automatic int clog2(input int v);
      int r;
      r = 0;
      while ((1 << r) < v) r++;
      return r;
   endfunction

endpackage

// File: rtl/lvds_urng_clz_if.sv
// rtl/lvds_urng_clz_if.sv - entropy input and collected-word/CLZ result bundle
interface lvds_urng_clz_if #(
   parameter int N      = 32,
   parameter int CLZ_BW = 14
);
   import lvds_urng_clz_pkg::*;

   localparam int CLZ_PW = clog2(CLZ_BW);

   logic              comparator_output;
   logic [N-1:0]      out;
   logic [N-1:0]      valid;
   logic [CLZ_PW-1:0] clz_count;
   logic              clz_valid;

   // Consumer side: supplies entropy, reads the word and its CLZ
   modport master (
      output comparator_output,
      input  out,
      input  valid,
      input  clz_count,
      input  clz_valid
   );

   // Collector side
   modport slave (
      input  comparator_output,
      output out,
      output valid,
      output clz_count,
      output clz_valid
   );

endinterface

// File: rtl/lvds_urng_clz_clz_reg.sv
// rtl/lvds_urng_clz_clz_reg.sv - registered count-leading-zeros priority encoder
module clz_reg
   import lvds_urng_clz_pkg::*;
#(
   parameter  int bits_in = DEF_CLZ_BW,
   localparam int PW      = clog2(bits_in)
) (
   input  logic               clk,
   input  logic               rst,
   input  logic [bits_in-1:0] b,
   output logic [PW-1:0]      pout,
   output logic               vout
);

   logic [PW-1:0] pout_q, pout_d;
   logic          vout_q, vout_d;

   // Priority encode: scanning upward, the highest set bit is the last hit and wins
   always_comb begin
      pout_d = '0;
      vout_d = 1'b0;
      for (int i = 0; i < bits_in; i++) begin
         if (b[i]) begin
            pout_d = PW'(bits_in - 1 - i);
            vout_d = 1'b1;
         end
      end
   end

   // Result register; a zero field leaves count at 0 with vout low
   always_ff @(posedge clk) begin
      if (rst) begin
         pout_q <= '0;
         vout_q <= 1'b0;
      end else begin
         pout_q <= pout_d;
         vout_q <= vout_d;
      end
   end

   assign pout = pout_q;
   assign vout = vout_q;

endmodule

// File: rtl/lvds_urng_clz.sv
// rtl/lvds_urng_clz.sv - serial entropy collector into an N-bit word with fill vector and field CLZ
// Optional feature macro: URNG_VON_NEUMANN_EN (accept only 01/10 pairs, shifting in the first bit)
module lvds_urng_clz
   import lvds_urng_clz_pkg::*;
#(
   parameter int N       = DEF_N,
   parameter int CLZ_LSB = DEF_CLZ_LSB,
   parameter int CLZ_BW  = DEF_CLZ_BW
) (
   input  logic               clk,
   input  logic               rst,
   lvds_urng_clz_if.slave     urng
);

   logic [N-1:0] out_q, out_d;
   logic [N-1:0] valid_q, valid_d;
   logic         full;
   logic         shift_en;
   logic         shift_bit;

   // The top fill bit only sets once every position has been sampled
   assign full = valid_q[N-1];

`ifdef URNG_VON_NEUMANN_EN
   vn_phase_e phase_q, phase_d;
   logic      first_q, first_d;

   // Pair tracker: latch the first bit, on the second emit it only if the pair differs
   always_comb begin
      phase_d   = phase_q;
      first_d   = first_q;
      shift_en  = 1'b0;
      shift_bit = first_q;
      if (!full) begin
         if (phase_q == PH_FIRST) begin
            phase_d = PH_SECOND;
            first_d = urng.comparator_output;
         end else begin
            phase_d  = PH_FIRST;
            shift_en = (first_q != urng.comparator_output);
         end
      end
   end

   // Pair phase register; frozen while full because the next-state logic holds it
   always_ff @(posedge clk) begin
      if (rst) begin
         phase_q <= PH_FIRST;
         first_q <= 1'b0;
      end else begin
         phase_q <= phase_d;
         first_q <= first_d;
      end
   end
`else
   assign shift_en  = !full;
   assign shift_bit = urng.comparator_output;
`endif

   // Shift collector: new bits enter at the LSB, the fill vector shifts in a one alongside
   always_comb begin
      out_d   = out_q;
      valid_d = valid_q;
      if (shift_en) begin
         out_d   = {out_q[N-2:0], shift_bit};
         valid_d = {valid_q[N-2:0], 1'b1};
      end
   end

   // Word and fill-vector registers; reset doubles as the consumer's refill request
   always_ff @(posedge clk) begin
      if (rst) begin
         out_q   <= '0;
         valid_q <= '0;
      end else begin
         out_q   <= out_d;
         valid_q <= valid_d;
      end
   end

   assign urng.out   = out_q;
   assign urng.valid = valid_q;

   clz_reg #(
      .bits_in (CLZ_BW)
   ) u_clz (
      .clk  (clk),
      .rst  (rst),
      .b    (out_q[CLZ_LSB +: CLZ_BW]),
      .pout (urng.clz_count),
      .vout (urng.clz_valid)
   );

endmodule

// File: tb/tb_lvds_urng_clz.sv
// tb/tb_lvds_urng_clz.sv - self-checking bench: vector table, corner sequences, randomized model compare
module tb_lvds_urng_clz;

   localparam int N   = 8;
   localparam int LSB = 0;
   localparam int BW  = 8;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   lvds_urng_clz_if #(.N(N), .CLZ_BW(BW)) uif ();

   lvds_urng_clz #(
      .N       (N),
      .CLZ_LSB (LSB),
      .CLZ_BW  (BW)
   ) dut (
      .clk  (clk),
      .rst  (rst),
      .urng (uif)
   );

   int tests = 0;
   int fails = 0;

   // Reference model: list of accepted bits since the last reset, pending pair bit, lagged CLZ
   bit mq[$];
   int pend = -1;
   int exp_cnt = 0;
   int exp_cv  = 0;

   function automatic int mdl_word();
      int w;
      w = 0;
      foreach (mq[j]) w = w * 2 + int'(mq[j]);
      return w;
   endfunction

   function automatic int mdl_valid();
      return (1 << mq.size()) - 1;
   endfunction

   task automatic clz_ref(input int word, output int cnt, output int nz);
      int field;
      int msb;
      field = (word >> LSB) & ((1 << BW) - 1);
      if (field == 0) begin
         cnt = 0;
         nz  = 0;
      end else begin
         msb = 0;
         while (field >= (1 << (msb + 1))) msb++;
         cnt = BW - 1 - msb;
         nz  = 1;
      end
   endtask

   task automatic mdl_update(input logic r, input logic c);
      if (r) begin
         mq.delete();
         pend    = -1;
         exp_cnt = 0;
         exp_cv  = 0;
      end else begin
         clz_ref(mdl_word(), exp_cnt, exp_cv);
         if (mq.size() < N) begin
`ifdef URNG_VON_NEUMANN_EN
            if (pend < 0) begin
               pend = int'(c);
            end else begin
               if (pend != int'(c)) mq.push_back(bit'(pend));
               pend = -1;
            end
`else
            mq.push_back(c);
`endif
         end
      end
   endtask

   task automatic step(input logic r, input logic c);
      rst = r;
      uif.comparator_output = c;
      mdl_update(r, c);
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] expv);
      tests++;
      if (act !== expv) begin
         fails++;
         $display("FAIL %s actual=%0h expected=%0h", nm, act, expv);
      end
   endtask

   task automatic chk_model(input string nm);
      chk({nm, ".out"},       32'(uif.out),       32'(mdl_word()));
      chk({nm, ".valid"},     32'(uif.valid),     32'(mdl_valid()));
      chk({nm, ".clz_count"}, 32'(uif.clz_count), 32'(exp_cnt));
      chk({nm, ".clz_valid"}, 32'(uif.clz_valid), 32'(exp_cv));
   endtask

   typedef struct {
      logic       cin;
      logic [7:0] out;
      logic [7:0] vld;
      logic [2:0] cnt;
      logic       cv;
   } vec_t;

   vec_t tbl[8];
   logic [7:0] words[3];
   logic [2:0] wcnt[3];
   logic       wcv[3];

   initial begin
      uif.comparator_output = 1'b0;

      // Reset with random input for three clocks
      for (int i = 0; i < 3; i++) step(1'b1, 1'($urandom));
      chk("reset.out",       32'(uif.out),       32'h0);
      chk("reset.valid",     32'(uif.valid),     32'h0);
      chk("reset.clz_count", 32'(uif.clz_count), 32'h0);
      chk("reset.clz_valid", 32'(uif.clz_valid), 32'h0);

`ifndef URNG_VON_NEUMANN_EN
      // Fill 1,0,1,1,0,0,1,0; CLZ lags the word by one clock
      tbl[0] = '{1'b1, 8'h01, 8'h01, 3'd0, 1'b0};
      tbl[1] = '{1'b0, 8'h02, 8'h03, 3'd7, 1'b1};
      tbl[2] = '{1'b1, 8'h05, 8'h07, 3'd6, 1'b1};
      tbl[3] = '{1'b1, 8'h0B, 8'h0F, 3'd5, 1'b1};
      tbl[4] = '{1'b0, 8'h16, 8'h1F, 3'd4, 1'b1};
      tbl[5] = '{1'b0, 8'h2C, 8'h3F, 3'd3, 1'b1};
      tbl[6] = '{1'b1, 8'h59, 8'h7F, 3'd2, 1'b1};
      tbl[7] = '{1'b0, 8'hB2, 8'hFF, 3'd1, 1'b1};
      for (int i = 0; i < 8; i++) begin
         step(1'b0, tbl[i].cin);
         chk($sformatf("fill%0d.out", i),   32'(uif.out),       32'(tbl[i].out));
         chk($sformatf("fill%0d.valid", i), 32'(uif.valid),     32'(tbl[i].vld));
         chk($sformatf("fill%0d.cnt", i),   32'(uif.clz_count), 32'(tbl[i].cnt));
         chk($sformatf("fill%0d.cv", i),    32'(uif.clz_valid), 32'(tbl[i].cv));
      end

      // Hold while full: ones are ignored, CLZ settles on the full word
      for (int i = 0; i < 10; i++) begin
         step(1'b0, 1'b1);
         chk($sformatf("hold%0d.out", i), 32'(uif.out), 32'hB2);
         if (i == 0) begin
            chk("hold.clz_count", 32'(uif.clz_count), 32'd0);
            chk("hold.clz_valid", 32'(uif.clz_valid), 32'd1);
         end
      end
      chk("hold.valid", 32'(uif.valid), 32'hFF);
      step(1'b1, 1'b1);
      chk("hold_rst.valid", 32'(uif.valid), 32'h0);
      for (int i = 0; i < 3; i++) step(1'b0, 1'b0);
      chk("refill.valid", 32'(uif.valid), 32'h07);
      chk("refill.out",   32'(uif.out),   32'h00);

      // CLZ of selected full words, read one clock after full
      words[0] = 8'h00; wcnt[0] = 3'd0; wcv[0] = 1'b0;
      words[1] = 8'h01; wcnt[1] = 3'd7; wcv[1] = 1'b1;
      words[2] = 8'h10; wcnt[2] = 3'd3; wcv[2] = 1'b1;
      for (int w = 0; w < 3; w++) begin
         step(1'b1, 1'b0);
         for (int k = N - 1; k >= 0; k--) step(1'b0, words[w][k]);
         step(1'b0, 1'b0);
         chk($sformatf("clz_w%0h.out", words[w]),   32'(uif.out),       32'(words[w]));
         chk($sformatf("clz_w%0h.cnt", words[w]),   32'(uif.clz_count), 32'(wcnt[w]));
         chk($sformatf("clz_w%0h.valid", words[w]), 32'(uif.clz_valid), 32'(wcv[w]));
      end

      // Reset after five bits, then a complete word needs eight more clocks
      step(1'b1, 1'b0);
      for (int i = 0; i < 5; i++) step(1'b0, 1'($urandom));
      chk("midfill.pre", 32'(uif.valid), 32'h1F);
      step(1'b1, 1'b1);
      chk("midfill.rst_valid", 32'(uif.valid), 32'h0);
      for (int i = 0; i < 7; i++) step(1'b0, 1'b1);
      chk("midfill.7clk", 32'(uif.valid), 32'h7F);
      step(1'b0, 1'b1);
      chk("midfill.8clk", 32'(uif.valid), 32'hFF);
      chk("midfill.out",  32'(uif.out),   32'hFF);
`else
      // Pairs 01,11,10,00,10 accept 0,1,1
      step(1'b1, 1'b0);
      begin
         logic [9:0] seq;
         seq = 10'b0111100010;
         for (int i = 9; i >= 0; i--) begin
            step(1'b0, seq[i]);
            if (i == 8) chk("vn.first_pair", 32'(uif.valid), 32'h01);
         end
      end
      chk("vn.valid", 32'(uif.valid), 32'h07);
      chk("vn.out",   32'(uif.out),   32'h03);
      chk_model("vn.model");
`endif

      // Randomized traffic against the reference model
      step(1'b1, 1'b0);
      for (int i = 0; i < 3000; i++) begin
         step(($urandom_range(0, 59) == 0), 1'($urandom));
         chk_model($sformatf("rand%0d", i));
      end

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
